// File: rtl/nes_pad_responder.sv
// rtl/nes_pad_responder.sv - NES pad emulator answering the reader's latch/clock with serial buttons
// Optional feature macro: NES_PAD_TURBO_EN (turbo on A/B buttons)
module nes_pad_responder #(
  parameter logic FILL_BIT     = 1'b1,
  parameter int   SYNC_STAGES  = 2,
  parameter int   TURBO_FRAMES = 4
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic       latch_in,
  input  logic       clk_in,
  input  logic [7:0] buttons,
  input  logic [1:0] turbo_mask,
  output logic       data_out,
  output logic [3:0] bit_cnt,
  output logic       frame_done,
  output logic       proto_err
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   latch_s;
  logic                   clk_s;
  logic                   latch_d;
  logic                   clk_d;
  logic                   latch_rise;
  logic                   clk_rise;

  logic [7:0] shift_reg;
  logic [7:0] eff_buttons;
  logic       do_load;
  logic       do_shift;
  logic       err_set;
  logic       done_set;

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign clk_s      = clk_sync[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_d;
  assign clk_rise   = clk_s & ~clk_d;

  // Synchronise the async protocol pins and keep one delayed copy for edge detection
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      latch_sync <= '0;
      clk_sync   <= '0;
      latch_d    <= 1'b0;
      clk_d      <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch_in};
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], clk_in};
      latch_d    <= latch_s;
      clk_d      <= clk_s;
    end
  end

`ifdef NES_PAD_TURBO_EN
  logic [2:0] turbo_cnt;
  logic       turbo_phase;
  logic       frame_phase;

  // Count latch frames; a frame loads with the phase in force before its own latch edge
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      turbo_cnt   <= 3'd0;
      turbo_phase <= 1'b0;
      frame_phase <= 1'b0;
    end else if (latch_rise) begin
      frame_phase <= turbo_phase;
      if (turbo_cnt == 3'(TURBO_FRAMES - 1)) begin
        turbo_cnt   <= 3'd0;
        turbo_phase <= ~turbo_phase;
      end else begin
        turbo_cnt <= turbo_cnt + 3'd1;
      end
    end
  end

  // Force turbo-enabled A/B buttons released during the off phase
  always_comb begin
    eff_buttons = buttons;
    if (!frame_phase) begin
      if (turbo_mask[0]) eff_buttons[0] = 1'b0;
      if (turbo_mask[1]) eff_buttons[1] = 1'b0;
    end
  end
`else
  logic turbo_unused;
  assign turbo_unused = ^turbo_mask ^ TURBO_FRAMES[0];
  assign eff_buttons  = buttons;
`endif

  // State register
  always_ff @(posedge clk_25mhz) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and datapath strobes; a synced latch always takes priority over a clk rise
  always_comb begin
    state_n  = state;
    do_load  = 1'b0;
    do_shift = 1'b0;
    err_set  = 1'b0;
    done_set = 1'b0;
    case (state)
      IDLE: begin
        if (latch_s) state_n = LOAD;
      end
      LOAD: begin
        if (!latch_s) begin
          state_n = SHIFT;
        end else begin
          do_load = 1'b1;
          err_set = clk_rise & ~latch_rise;
        end
      end
      SHIFT: begin
        if (latch_s) begin
          state_n = LOAD;
        end else if (clk_rise) begin
          do_shift = 1'b1;
          if (bit_cnt == 4'd7) begin
            done_set = 1'b1;
            state_n  = DONE;
          end
        end
      end
      DONE: begin
        if (latch_s) state_n = LOAD;
        else if (clk_rise) do_shift = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Shift register, edge counter, pulses and the registered serial line
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      shift_reg  <= 8'h00;
      bit_cnt    <= 4'd0;
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
      data_out   <= 1'b1;
    end else begin
      if (do_load) begin
        shift_reg <= eff_buttons;
        bit_cnt   <= 4'd0;
      end else if (do_shift) begin
        shift_reg <= {FILL_BIT, shift_reg[7:1]};
        if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
      end
      frame_done <= done_set;
      proto_err  <= err_set;
      data_out   <= (state == IDLE) ? 1'b1 : ~shift_reg[0];
    end
  end

endmodule

// File: tb/tb_nes_pad_responder.sv
// tb/tb_nes_pad_responder.sv - randomized self-checking bench for nes_pad_responder
`timescale 1ns/1ps
module tb_nes_pad_responder;

  localparam int   TF   = 4;
  localparam logic FILL = 1'b1;
`ifdef NES_PAD_TURBO_EN
  localparam bit TURBO_ON = 1'b1;
`else
  localparam bit TURBO_ON = 1'b0;
`endif

  logic       clk_25mhz = 1'b0;
  logic       rst;
  logic       latch_in;
  logic       clk_in;
  logic [7:0] buttons;
  logic [1:0] turbo_mask;
  logic       data_out;
  logic [3:0] bit_cnt;
  logic       frame_done;
  logic       proto_err;

  int n_vec = 0;
  int n_err = 0;
  int fd_cnt = 0;
  int pe_cnt = 0;
  int frame_idx = 0;

  nes_pad_responder dut (
    .clk_25mhz (clk_25mhz),
    .rst       (rst),
    .latch_in  (latch_in),
    .clk_in    (clk_in),
    .buttons   (buttons),
    .turbo_mask(turbo_mask),
    .data_out  (data_out),
    .bit_cnt   (bit_cnt),
    .frame_done(frame_done),
    .proto_err (proto_err)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  always @(negedge clk_25mhz) begin
    if (!rst) begin
      if (frame_done) fd_cnt++;
      if (proto_err)  pe_cnt++;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (frame %0d)", tag, got, exp, frame_idx);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  // Buttons a pad would present for a given frame number since reset
  function automatic logic [7:0] model_buttons(input logic [7:0] b, input logic [1:0] m, input int frame);
    logic [7:0] r;
    r = b;
    if (TURBO_ON && (((frame / TF) % 2) == 0)) begin
      if (m[0]) r[0] = 1'b0;
      if (m[1]) r[1] = 1'b0;
    end
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    latch_in = 1'b0;
    clk_in = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    frame_idx = 0;
  endtask

  task automatic run_frame(input logic [7:0] btn, input logic [1:0] mask, input int rises,
                           input int lat_hi, input int clk_hi, input int clk_lo,
                           input logic [7:0] btn_after, input bit glitch);
    logic [7:0] exp_b;
    logic [8:0] serial;
    int fd0, pe0, samp;
    exp_b  = model_buttons(btn, mask, frame_idx);
    serial = {FILL, exp_b};
    samp   = (clk_hi > 25) ? 25 : clk_hi - 1;
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    buttons = btn;
    turbo_mask = mask;
    latch_in = 1'b1;
    if (glitch) begin
      wait_cyc(6);
      clk_in = 1'b1;
      wait_cyc(6);
      clk_in = 1'b0;
      wait_cyc(6);
      check_eq("latched_bit_cnt", bit_cnt, 0);
    end
    wait_cyc(lat_hi);
    latch_in = 1'b0;
    wait_cyc(4);
    buttons = btn_after;
    wait_cyc(clk_lo - 4);
    check_eq("first_bit", data_out, !serial[0]);
    check_eq("start_bit_cnt", bit_cnt, 0);
    for (int k = 1; k <= rises; k++) begin
      clk_in = 1'b1;
      wait_cyc(samp);
      check_eq("serial_bit", data_out, !serial[(k < 8) ? k : 8]);
      check_eq("bit_cnt", bit_cnt, (k < 8) ? k : 8);
      wait_cyc(clk_hi - samp);
      clk_in = 1'b0;
      wait_cyc(clk_lo);
    end
    check_eq("frame_done_pulses", fd_cnt - fd0, (rises >= 8) ? 1 : 0);
    check_eq("proto_err_pulses", pe_cnt - pe0, glitch ? 1 : 0);
    frame_idx++;
  endtask

  initial begin
    buttons = 8'h00;
    turbo_mask = 2'b00;
    rst = 1'b1;
    latch_in = 1'b0;
    clk_in = 1'b0;
    wait_cyc(3);
    check_eq("rst_data_out", data_out, 1);
    check_eq("rst_bit_cnt", bit_cnt, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_proto_err", proto_err, 0);
    rst = 1'b0;
    frame_idx = 0;

    for (int i = 0; i < 100; i++) begin
      wait_cyc(1);
      if (i % 25 == 24) begin
        check_eq("idle_data_out", data_out, 1);
        check_eq("idle_bit_cnt", bit_cnt, 0);
      end
    end
    check_eq("idle_pulses", fd_cnt + pe_cnt, 0);

    // Full-rate frame; buttons change to FF after the latch falls
    run_frame(8'b1000_0101, 2'b00, 8, 300, 150, 150, 8'hFF, 1'b0);
    // Clock pulse while latched
    run_frame(8'h3C, 2'b00, 8, 10, 8, 8, 8'h3C, 1'b1);
    // Re-latch after three rises
    run_frame(8'hA5, 2'b00, 3, 10, 8, 8, 8'hA5, 1'b0);
    run_frame(8'h02, 2'b00, 8, 10, 8, 8, 8'h02, 1'b0);
    // Further rises in DONE keep shifting fill
    run_frame(8'h81, 2'b00, 10, 10, 8, 8, 8'h81, 1'b0);

    // Reset mid-frame
    run_frame(8'hFF, 2'b00, 3, 10, 8, 8, 8'hFF, 1'b0);
    rst = 1'b1;
    wait_cyc(1);
    check_eq("midrst_data_out", data_out, 1);
    check_eq("midrst_bit_cnt", bit_cnt, 0);
    rst = 1'b0;
    frame_idx = 0;

    // Turbo on A over 16 frames
    for (int f = 0; f < 16; f++) run_frame(8'h01, 2'b01, 8, 10, 7, 8, 8'h01, 1'b0);

    do_reset();
    for (int f = 0; f < 40; f++) begin
      logic [7:0] b;
      b = 8'($urandom);
      run_frame(b, 2'($urandom_range(0, 3)), $urandom_range(0, 10),
                $urandom_range(6, 20), $urandom_range(6, 12), $urandom_range(8, 14),
                8'($urandom), ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nes_pad_responder.md
Name: nes_pad_responder

Overview:
Emulates the NES controller side of the serial pad protocol: it answers the latch/clock pair driven by the console-side controller reader with serial button data. It sits between board buttons (or a bench stimulus) and the controller reader's data_in, so the reader can run end-to-end on hardware without a physical pad. All protocol inputs are asynchronous and are synchronised internally to clk_25mhz.

Parameters:
FILL_BIT, 1, value shifted in behind the 8 button bits; 1 means "pressed", so the line is driven low.
SYNC_STAGES, 2, flip-flop stages in the latch_in/clk_in synchronisers; legal range 2..3.
TURBO_FRAMES, 4, latch frames per turbo half-period; used only with the optional feature.

Ports:
clk_25mhz  input  1  system clock
rst  input  1  synchronous, active-high reset
latch_in  input  1  latch from the reader, async, active-high
clk_in  input  1  shift clock from the reader, async; shift on rising edge
buttons  input  8  1 = pressed; [0]=A [1]=B [2]=Select [3]=Start [4]=Up [5]=Down [6]=Left [7]=Right
turbo_mask  input  2  [0]=turbo on A, [1]=turbo on B; ignored without TURBO_EN
data_out  output  1  serial line to reader, active-low (0 = pressed), registered
bit_cnt  output  4  clk_in rising edges accepted this frame, saturates at 8
frame_done  output  1  one-cycle pulse when the 8th edge is accepted
proto_err  output  1  one-cycle pulse when a clk_in rise arrives while latch is high

Behaviour:
- Reset values: data_out=1, shift_reg=8'h00, bit_cnt=0, frame_done=0, proto_err=0, state=IDLE, turbo frame counter and phase=0.
- latch_in and clk_in each pass through SYNC_STAGES flip-flops, then one edge-detect register. A pin edge becomes visible as an internal pulse 3 cycles later (SYNC_STAGES=2).
- data_out is registered and always equals ~shift_reg[0], except in IDLE where it is 1. Worst-case delay from a pin edge to a data_out change is 4 cycles (160 ns). The reader must sample at least 4 cycles after its clk_out rise.
- State machine:
  - IDLE: data_out=1. Synced latch high -> LOAD.
  - LOAD: every cycle shift_reg<=effective buttons, bit_cnt<=0. clk_in rises are ignored and each one pulses proto_err. Synced latch falling edge -> SHIFT; shift_reg is frozen at the value loaded on the last latch-high cycle.
  - SHIFT: each clk_in rise does shift_reg<={FILL_BIT, shift_reg[7:1]} and bit_cnt+1. The rise that makes bit_cnt=8 also pulses frame_done in the same cycle as the bit_cnt update, and the next state is DONE.
  - DONE: further clk_in rises keep shifting FILL_BIT in. bit_cnt holds at 8 and frame_done does not repeat.
- Synced latch high in SHIFT or DONE aborts the frame -> LOAD (re-latch mid-frame is legal, with no error).
- A latch rise and a clk rise in the same cycle: the latch wins, the clk rise is discarded, and proto_err is not pulsed.
- A latch pulse with no clk edges afterwards: the machine stays in SHIFT indefinitely presenting the A bit. There is no timeout.
- rst asserted at any time, including mid-frame, returns to the reset values on the next edge.
- buttons is sampled only in LOAD and needs no synchroniser beyond that register; glitches while latched are reloaded on the next cycle.

Optional Feature:
NES_PAD_TURBO_EN
- Defined:
  - A 3-bit frame counter increments on each synced latch rising edge and wraps at TURBO_FRAMES-1, toggling turbo_phase at the wrap.
  - When turbo_phase=0, buttons[i] for i in {0,1} with turbo_mask[i]=1 is forced to 0 in the load path.
  - Counter and phase reset to 0.
- Undefined: no counter is built, turbo_mask is unconnected, and the load path uses buttons unmodified.

Test Plan:
- Reset, then hold latch_in=0 and clk_in=0 -> data_out=1, bit_cnt=0, no pulses for 100 cycles.
- buttons=8'b1000_0101; latch 12 us high; 8 clk_in pulses at 6 us high / 6 us low; sample 1 us after each rise -> data_out before pulse 1 = 0 (A). After rises 1..7: 1,0,1,1,1,1,0. After rise 8: 0 (FILL). frame_done pulses once, bit_cnt=8.
- Same frame, change buttons to 8'hFF after the latch falls -> serial bits are unchanged (the frozen value 8'b1000_0101).
- Latch high, then a clk_in pulse while latch stays high -> exactly one proto_err pulse, bit_cnt stays 0, and the frame after latch falls is correct.
- Re-latch after 3 clk rises with buttons=8'h02 -> bit_cnt returns to 0, data_out=1 then 0 after the first rise (B), then 8 more rises complete normally.
- With NES_PAD_TURBO_EN, TURBO_FRAMES=4, buttons=8'h01, turbo_mask=2'b01 over 16 frames -> A reads released in frames 0-3 and 8-11, pressed in frames 4-7 and 12-15. Without the macro, A reads pressed in all 16 frames.
